gpu_instruction_dispatcher: RTL

GPU_INSTRUCTION_DISPATCHER -- requirements
Module: gpu_instruction_dispatcher

---
 rtl/gpu_instruction_dispatcher.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/gpu_instruction_dispatcher.sv
// GPU instruction dispatcher: fetches one instruction from the FIFO head,
// decodes it, starts the matching raster engine and waits for its done
// (or a timeout) before fetching again. All outputs come from flops.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_instruction_dispatcher #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  // Reset value of instr_count_o; left at zero except to exercise the wrap.
  parameter logic [15:0] COUNT_PRESET   = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic                     fifo_empty_i,
  output logic                     pop_instruction_o,
  input  logic [3:0]               opcode_i,
  input  logic [`WIDTH_BITS-1:0]   x1_i,
  input  logic [`WIDTH_BITS-1:0]   x2_i,
  input  logic [`WIDTH_BITS-1:0]   rad_i,
  input  logic [`HEIGHT_BITS-1:0]  y1_i,
  input  logic [`HEIGHT_BITS-1:0]  y2_i,
  input  logic [`CHANNEL_BITS-1:0] r_i,
  input  logic [`CHANNEL_BITS-1:0] g_i,
  input  logic [`CHANNEL_BITS-1:0] b_i,
  input  logic [2:0]               quad_i,
  output logic [`WIDTH_BITS-1:0]   x1_o,
  output logic [`WIDTH_BITS-1:0]   x2_o,
  output logic [`WIDTH_BITS-1:0]   rad_o,
  output logic [`HEIGHT_BITS-1:0]  y1_o,
  output logic [`HEIGHT_BITS-1:0]  y2_o,
  output logic [`CHANNEL_BITS-1:0] r_o,
  output logic [`CHANNEL_BITS-1:0] g_o,
  output logic [`CHANNEL_BITS-1:0] b_o,
  output logic [2:0]               quad_o,
  output logic                     start_line_o,
  output logic                     start_circle_o,
  output logic                     start_rect_o,
  input  logic                     line_done_i,
  input  logic                     circle_done_i,
  input  logic                     rect_done_i,
  output logic                     abort_o,
  output logic                     timeout_o,
  output logic                     err_illegal_o,
  output logic                     frame_done_o,
  output logic                     busy_o,
  output logic [15:0]              instr_count_o
);

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_LINE   = 4'b0100;
  localparam logic [3:0] OP_CIRCLE = 4'b0101;
  localparam logic [3:0] OP_RECT   = 4'b0110;
  localparam logic [3:0] OP_FLUSH  = 4'b1111;

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DECODE, DISPATCH, WAIT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]               r_opcode;
  logic [`WIDTH_BITS-1:0]   r_x1, r_x2, r_rad;
  logic [`HEIGHT_BITS-1:0]  r_y1, r_y2;
  logic [`CHANNEL_BITS-1:0] r_r, r_g, r_b;
  logic [2:0]               r_quad;
  logic [TW-1:0]            r_timer;
  logic [15:0]              r_count;
  logic r_pop, r_start_line, r_start_circle, r_start_rect;
  logic r_timeout, r_err, r_frame, r_busy;

  logic w_fetch, w_start_line, w_start_circle, w_start_rect;
  logic w_timeout, w_err, w_frame, w_count_inc, w_timer_clr, w_timer_inc;
  logic w_done_sel;

  // Only the engine that was dispatched may complete the instruction.
  always_comb begin
    w_done_sel = 1'b0;
    case (r_opcode)
      OP_LINE:   w_done_sel = line_done_i;
      OP_CIRCLE: w_done_sel = circle_done_i;
      OP_RECT:   w_done_sel = rect_done_i;
      default:   w_done_sel = 1'b0;
    endcase
  end

  // Next-state and next-pulse decode; every pulse defaults low.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch        = 1'b0;
    w_start_line   = 1'b0;
    w_start_circle = 1'b0;
    w_start_rect   = 1'b0;
    w_timeout      = 1'b0;
    w_err          = 1'b0;
    w_frame        = 1'b0;
    w_count_inc    = 1'b0;
    w_timer_clr    = 1'b0;
    w_timer_inc    = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable_i && !fifo_empty_i) begin
          w_fetch     = 1'b1;
          w_state_nxt = DECODE;
        end
      end
      DECODE: begin
        case (r_opcode)
          OP_LINE, OP_CIRCLE, OP_RECT: w_state_nxt = DISPATCH;
          OP_NOP:   w_state_nxt = IDLE;
          OP_FLUSH: begin
            w_frame     = 1'b1;
            w_state_nxt = IDLE;
          end
          default: begin
            w_err       = 1'b1;
            w_state_nxt = IDLE;
          end
        endcase
      end
      DISPATCH: begin
        w_start_line   = (r_opcode == OP_LINE);
        w_start_circle = (r_opcode == OP_CIRCLE);
        w_start_rect   = (r_opcode == OP_RECT);
        w_timer_clr    = 1'b1;
        w_state_nxt    = WAIT;
      end
      WAIT: begin
        // A done arriving on the last timer cycle still counts as done.
        if (w_done_sel) begin
          w_count_inc = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_timer == TIMER_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, latched instruction, counters and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_busy         <= 1'b0;
      r_pop          <= 1'b0;
      r_start_line   <= 1'b0;
      r_start_circle <= 1'b0;
      r_start_rect   <= 1'b0;
      r_timeout      <= 1'b0;
      r_err          <= 1'b0;
      r_frame        <= 1'b0;
      r_opcode       <= 4'b0000;
      r_x1           <= '0;
      r_x2           <= '0;
      r_rad          <= '0;
      r_y1           <= '0;
      r_y2           <= '0;
      r_r            <= '0;
      r_g            <= '0;
      r_b            <= '0;
      r_quad         <= 3'b000;
      r_timer        <= '0;
      r_count        <= COUNT_PRESET;
    end else begin
      r_state        <= w_state_nxt;
      r_busy         <= (w_state_nxt != IDLE);
      r_pop          <= w_fetch;
      r_start_line   <= w_start_line;
      r_start_circle <= w_start_circle;
      r_start_rect   <= w_start_rect;
      r_timeout      <= w_timeout;
      r_err          <= w_err;
      r_frame        <= w_frame;
      // The operand bus is the latched head; it only changes on a fetch.
      if (w_fetch) begin
        r_opcode <= opcode_i;
        r_x1     <= x1_i;
        r_x2     <= x2_i;
        r_rad    <= rad_i;
        r_y1     <= y1_i;
        r_y2     <= y2_i;
        r_r      <= r_i;
        r_g      <= g_i;
        r_b      <= b_i;
        r_quad   <= quad_i;
      end
      if (w_count_inc) begin
        r_count <= r_count + 16'd1;
      end
      if (w_timer_clr) begin
        r_timer <= '0;
      end else if (w_timer_inc) begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  assign pop_instruction_o = r_pop;
  assign start_line_o      = r_start_line;
  assign start_circle_o    = r_start_circle;
  assign start_rect_o      = r_start_rect;
  assign timeout_o         = r_timeout;
  assign abort_o           = r_timeout;
  assign err_illegal_o     = r_err;
  assign frame_done_o      = r_frame;
  assign busy_o            = r_busy;
  assign instr_count_o     = r_count;
  assign x1_o              = r_x1;
  assign x2_o              = r_x2;
  assign rad_o             = r_rad;
  assign y1_o              = r_y1;
  assign y2_o              = r_y2;
  assign r_o               = r_r;
  assign g_o               = r_g;
  assign b_o               = r_b;
  assign quad_o            = r_quad;

endmodule
